// File: rtl/weight_update.sv
// Weight-update engine: reads one 256-bit weight word, applies w -= (d*x)>>>SHIFT with saturation, writes it back.
// Latency N+5 cycles from start (N = 24 or 12); no backpressure, start is ignored while busy.
module weight_update #(
  parameter int WWIDTH = 8,
  parameter int SHIFT  = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic         layer,
  input  logic [8:0]   x0,
  input  logic [8:0]   x1,
  input  logic [8:0]   x2,
  input  logic [8:0]   x3,
  input  logic [8:0]   v0,
  input  logic [8:0]   v1,
  input  logic [8:0]   v2,
  input  logic [8:0]   v3,
  input  logic [8:0]   v4,
  input  logic [8:0]   v5,
  input  logic [8:0]   d0,
  input  logic [8:0]   d1,
  input  logic [8:0]   d2,
  input  logic [8:0]   d3,
  input  logic [8:0]   d4,
  input  logic [8:0]   d5,
  input  logic [255:0] mem_rdata,
  output logic [3:0]   mem_addr,
  output logic [255:0] mem_wdata,
  output logic         mem_we,
  output logic         busy,
  output logic         done
);

  localparam int AW = WWIDTH + 19;
  localparam logic signed [AW-1:0] W_MAX = {{(AW-WWIDTH+1){1'b0}}, {(WWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] W_MIN = {{(AW-WWIDTH+1){1'b1}}, {(WWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT, LATCH, UPD, WR, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_layer;
  logic [3:0]     r_addr;
  logic [255:0]   r_buf;
  logic [4:0]     r_k;
  logic [2:0]     r_i;
  logic [2:0]     r_j;
  logic [8:0]     r_x [4];
  logic [8:0]     r_v [6];
  logic [8:0]     r_d [6];

  logic [4:0]              w_n;
  logic [2:0]              w_ilast;
  logic [8:0]              w_op;
  logic [8:0]              w_dj;
  logic [7:0]              w_pos;
  logic [WWIDTH-1:0]       w_old;
  logic signed [17:0]      w_prod;
  logic signed [17:0]      w_step;
  logic signed [AW-1:0]    w_wext;
  logic signed [AW-1:0]    w_sext;
  logic signed [AW-1:0]    w_diff;
  logic [WWIDTH-1:0]       w_new;

  assign w_n     = r_layer ? 5'd12 : 5'd24;
  assign w_ilast = r_layer ? 3'd5 : 3'd3;
  assign w_op    = r_layer ? r_v[r_i] : r_x[r_i[1:0]];
  assign w_dj    = r_d[r_j];
  assign w_pos   = 8'(WWIDTH * int'(r_k));
  assign w_old   = r_buf[w_pos +: WWIDTH];

  // Full-precision product, floor shift, then subtract with enough headroom to saturate exactly.
  assign w_prod  = $signed({{9{w_dj[8]}}, w_dj}) * $signed({{9{w_op[8]}}, w_op});
  assign w_step  = w_prod >>> SHIFT;
  assign w_wext  = {{(AW-WWIDTH){w_old[WWIDTH-1]}}, w_old};
  assign w_sext  = {{(AW-18){w_step[17]}}, w_step};
  assign w_diff  = w_wext - w_sext;
  assign w_new   = (w_diff > W_MAX) ? W_MAX[WWIDTH-1:0] :
                   (w_diff < W_MIN) ? W_MIN[WWIDTH-1:0] : w_diff[WWIDTH-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = WAIT;
      WAIT:    w_next = LATCH;
      LATCH:   w_next = UPD;
      UPD:     if (r_k == w_n) w_next = WR;
      WR:      w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_we = (r_state == WR);
    done   = (r_state == DONE);
    busy   = (r_state != IDLE);
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_buf;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_layer <= 1'b0;
      r_addr  <= '0;
      r_buf   <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      for (int n = 0; n < 4; n++) r_x[n] <= '0;
      for (int n = 0; n < 6; n++) r_v[n] <= '0;
      for (int n = 0; n < 6; n++) r_d[n] <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_layer <= layer;
          r_addr  <= {3'b000, layer};
          r_x[0] <= x0; r_x[1] <= x1; r_x[2] <= x2; r_x[3] <= x3;
          r_v[0] <= v0; r_v[1] <= v1; r_v[2] <= v2;
          r_v[3] <= v3; r_v[4] <= v4; r_v[5] <= v5;
          r_d[0] <= d0; r_d[1] <= d1; r_d[2] <= d2;
          r_d[3] <= d3; r_d[4] <= d4; r_d[5] <= d5;
        end
        LATCH: begin
          r_buf <= mem_rdata;
          r_k   <= '0;
          r_i   <= '0;
          r_j   <= '0;
        end
        // r_k == N is a one-cycle drain that lines the write up with its fixed slot.
        UPD: if (r_k != w_n) begin
          r_buf[w_pos +: WWIDTH] <= w_new;
          r_k <= r_k + 5'd1;
          if (r_i == w_ilast) begin
            r_i <= '0;
            r_j <= r_j + 3'd1;
          end else begin
            r_i <= r_i + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
